// File: rtl/dm_uart_tx_if.sv
// rtl/dm_uart_tx_if.sv - data-memory load/store bus seen by the UART responder
interface dm_uart_tx_if;
   logic        we;
   logic [2:0]  dop;
   logic [31:0] dm_addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        hit;

   modport master (
      output we, dop, dm_addr, data_in,
      input  data_out, hit
   );

   modport slave (
      input  we, dop, dm_addr, data_in,
      output data_out, hit
   );
endinterface

// File: rtl/dm_uart_tx.sv
// rtl/dm_uart_tx.sv - memory-mapped UART transmitter with TX FIFO on the data-memory port
module dm_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter logic [15:0] CLK_DIV    = 16'd868,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   dm_uart_tx_if.slave    bus,
   output logic           tx,
   output logic           tx_busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          overflow;
   logic [15:0]   div;
   logic [15:0]   eff_div;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   logic          wr;
   logic [1:0]    offset;
   logic          full;
   logic          empty;
   logic          bit_end;
   logic          pop;
   logic          push_req;
   logic          push;
   logic [31:0]   reg_word;
   logic [31:0]   lane;
   logic [31:0]   rd_data;
   logic          unused_data_hi;

   assign bus.hit   = (bus.dm_addr[31:4] == BASE_ADDR[31:4]);
   assign wr        = bus.we & bus.hit;
   assign offset    = bus.dm_addr[3:2];
   assign full      = (count == DEPTH_CNT);
   assign empty     = (count == '0);
   assign eff_div   = (div == 16'd0) ? 16'd1 : div;
   assign bit_end   = (baud_cnt == 16'd0);
   // The shifter consumes a byte either when starting from idle or when a stop bit ends back-to-back.
   assign pop       = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
   assign push_req  = wr && (offset == 2'd0);
   assign push      = push_req && (!full || pop);
   assign unused_data_hi = ^bus.data_in[31:16];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bus.data_in[7:0];
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && full && !pop)
            overflow <= 1'b1;
         else if (wr && (offset == 2'd1) && bus.data_in[3])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         div <= CLK_DIV;
      else if (wr && (offset == 2'd2)) begin
         if (bus.dop[1:0] == 2'd0)
            div[7:0] <= bus.data_in[7:0];
         else
            div <= bus.data_in[15:0];
      end
   end

   // Each bit holds for eff_div clocks; the divider is re-read only on reloads, i.e. at bit boundaries.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  shreg    <= fifo_mem[rd_ptr];
                  tx       <= 1'b0;
                  tx_busy  <= 1'b1;
                  baud_cnt <= eff_div - 16'd1;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= eff_div - 16'd1;
                  tx       <= shreg[0];
                  bit_idx  <= '0;
                  state    <= DATA;
               end else
                  baud_cnt <= baud_cnt - 16'd1;
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= eff_div - 16'd1;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx      <= shreg[1];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else
                  baud_cnt <= baud_cnt - 16'd1;
            end
            STOP: begin
               if (bit_end) begin
                  if (!empty) begin
                     shreg    <= fifo_mem[rd_ptr];
                     tx       <= 1'b0;
                     baud_cnt <= eff_div - 16'd1;
                     state    <= START;
                  end else begin
                     tx_busy <= 1'b0;
                     state   <= IDLE;
                  end
               end else
                  baud_cnt <= baud_cnt - 16'd1;
            end
            default: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      reg_word = 32'd0;
      case (offset)
         2'd1:    reg_word = {28'd0, overflow, tx_busy, empty, full};
         2'd2:    reg_word = {16'd0, div};
         default: reg_word = 32'd0;
      endcase
      lane = reg_word >> {bus.dm_addr[1:0], 3'b000};
      case (bus.dop)
         3'd0:    rd_data = {{24{lane[7]}}, lane[7:0]};
         3'd1:    rd_data = {{16{lane[15]}}, lane[15:0]};
         3'd4:    rd_data = {24'd0, lane[7:0]};
         3'd5:    rd_data = {16'd0, lane[15:0]};
         default: rd_data = reg_word;
      endcase
   end

   assign bus.data_out = bus.hit ? rd_data : 32'd0;
endmodule

// File: doc/dm_uart_tx.md
Name: dm_uart_tx

Overview:
- Memory-mapped UART transmitter that sits on the CPU data-memory port as a responder, in parallel with dm_control.
- It decodes the same store/load bus the core drives: ALU address, rs2 write data, funct3 op and write enable.
- It answers loads with register contents and serialises stored bytes onto a TX pin through a small FIFO.
- A top-level write-back mux selects data_out over RAM data when hit=1.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window. Bits [3:0] are ignored.
- CLK_DIV, 16'd868, reset value of the baud divider in clocks per bit.
- FIFO_DEPTH, 4, TX FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  store enable from the decoder (mwe).
- dop  in  3  funct3 of the load/store: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- dm_addr  in  32  byte address (ALU output).
- data_in  in  32  store data (rs2).
- data_out  out  32  load data. Combinational from registers.
- hit  out  1  dm_addr[31:4] == BASE_ADDR[31:4]. Combinational.
- tx  out  1  serial output, idle high. Registered.
- tx_busy  out  1  shifter not in IDLE. Registered.

Behaviour:
- Register map (offset = dm_addr[3:0] word-aligned):
  - 0x0 TXDATA (write-only, reads 0).
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow, all other bits 0. A write with data_in[3]=1 clears overflow.
  - 0x8 DIV: bits [15:0] read/write, upper bits read 0.
  - 0xC: reads 0, writes ignored.
- Reset values: tx=1, tx_busy=0, FIFO empty, overflow=0, DIV=CLK_DIV, state IDLE.
- Reset asserted mid-frame aborts the frame; tx=1 after that edge and FIFO contents are discarded.
- Write strobe is we & hit, sampled at the rising edge. Stores never stall and take effect at that edge.
- TXDATA push:
  - The byte pushed is data_in[7:0] for SB, SH and SW.
  - If the FIFO is full and no pop happens on the same edge, the byte is dropped and overflow is set (sticky).
  - Full with a pop on the same edge: the push is accepted and the count is unchanged.
- DIV writes:
  - SW and SH write data_in[15:0]. SB writes the low byte only.
  - A stored value of 0 is treated as 1.
  - A new DIV takes effect at the next bit boundary, not mid-bit.
- Load data:
  - Lane is selected by dm_addr[1:0] on the addressed 32-bit register value.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
  - data_out = 0 when hit=0.
  - Loads have no side effects.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop at the edge, tx<=0, state START, baud counter <= DIV-1.
  - Each bit lasts exactly DIV clocks. The counter decrements to 0; at 0 the counter reloads and the state advances.
  - START -> DATA: tx<=byte[0].
  - DATA: shifts LSB first through 8 bits, bit index 0..7. After bit 7, tx<=1 and state STOP.
  - STOP end, FIFO non-empty: pop and go straight to START with no idle gap.
  - STOP end, FIFO empty: go to IDLE.
  - Frame length is exactly 10*DIV clocks.
- Latency: a store at edge N into an empty FIFO with FSM in IDLE gives tx=0 after edge N+1.
- tx_busy = (state != IDLE). FIFO empty/full flags reflect occupancy after each edge. Read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, then read STATUS (LW 0x1000_0004) -> 0x0000_0002 (empty); tx=1, tx_busy=0. Read DIV -> 0x0000_0364.
- SW 4 -> 0x1000_0008, then SB 0xA5 -> 0x1000_0000.
  - tx low one edge after the store, held 4 clocks.
  - Data bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop bit high.
  - tx_busy drops exactly 40 clocks after the pop.
- DIV=4; store 0x55, 0x0F, 0xF0 back-to-back.
  - Three contiguous 40-clock frames with no idle clocks between stop and start.
  - STATUS bit1=1 after the third pop.
- DIV=100; store 6 bytes in 6 consecutive cycles.
  - First byte popped, next 4 fill the FIFO, 6th dropped.
  - STATUS = 0x0000_000D (full, busy, overflow).
  - SW 0x8 -> 0x1000_0004 clears overflow to give STATUS 0x5.
  - Only 5 frames are transmitted.
- Load lane and sign checks:
  - DIV=0x8080: LB 0x1000_0008 -> 0xFFFF_FF80.
  - LBU 0x1000_0009 -> 0x0000_0080.
  - LH -> 0xFFFF_8080, LHU -> 0x0000_8080.
  - Access to 0x2000_0008 gives hit=0 and data_out=0.
- Assert reset for 1 cycle in the middle of a DATA bit -> next cycle tx=1, tx_busy=0, STATUS=0x2, no further frames.
